uturn_ctrl: RTL and testbench
=============================

Name: uturn_ctrl

Overview:
- Downstream stage of the core controller: executes the U-turn when the core raises en_uturn, and reports completion back on uturn_finished.
- Sequence: drives both wheel motors through back-off, spin-off-line, spin-to-reacquire and brake phases, using the reflective line-sensor array.
- Owns motor direction/PWM while enabled. Tracking owns them otherwise; the top-level mux selects by en_uturn.

Parameters:
- PWM_PERIOD, 1000, PWM period in clk cycles.
- SPIN_DUTY, 600, on-cycles per period during spin phases (must be < PWM_PERIOD).
- BACK_DUTY, 400, on-cycles per period during back-off.
- BACK_CYCLES, 5000000, back-off duration in clk cycles.
- DEBOUNCE, 16, consecutive cycles a centre-sensor condition must hold.
- BRAKE_CYCLES, 1000000, motors-off settle time before reporting done.
- TIMEOUT_CYCLES, 200000000, maximum enable-to-done time (optional feature only).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- en  input  1  en_uturn from core; level
- sensors  input  5  line sensors, bit 2 = centre, 1 = line seen
- uturn_finished  output  1  level, high in DONE until en falls
- busy  output  1  high in any state other than IDLE/DONE/FAULT
- motor_l_dir  output  1  left wheel, 1 = forward
- motor_r_dir  output  1  right wheel, 1 = forward
- motor_l_pwm  output  1  left wheel PWM
- motor_r_pwm  output  1  right wheel PWM
- fault  output  1  timeout flag (0 when feature compiled out)

Behaviour:
- Reset (rst_n low at a clk edge):
  - state IDLE; all counters 0.
  - All outputs 0, including dir (dir is don't-care while pwm is 0).
- Inputs: sensors pass through a 2-flop synchroniser. Debounce compares the synchronised centre bit.
- States:
  - IDLE: motors off. en high -> BACKUP on the next edge; back-off counter cleared.
  - BACKUP: both dir 0, duty BACK_DUTY. After BACK_CYCLES cycles -> LEAVE.
  - LEAVE: left dir 1, right dir 0 (clockwise spin), duty SPIN_DUTY. Centre 0 for DEBOUNCE consecutive cycles -> SEEK. Any 1 resets the debounce count.
  - SEEK: same spin. Centre 1 for DEBOUNCE consecutive cycles -> BRAKE.
  - BRAKE: pwm 0. After BRAKE_CYCLES -> DONE.
  - DONE: uturn_finished 1, motors off. en low -> IDLE; uturn_finished drops in that same transition.
- Output timing:
  - Outputs are registered, so the first PWM-high occurs 1 cycle after entering BACKUP.
  - PWM counter resets to 0 on every state change. pwm = (count < duty) in BACKUP/LEAVE/SEEK, else 0.
- Abort: en low in any state other than IDLE -> IDLE next edge; motors off and busy 0 the following cycle.
- Restart: en re-asserted while in DONE has no effect; en must fall and rise again.
- Counter widths: $clog2 of the respective parameter + 1. Counters saturate and never wrap.
- Simultaneity: en low takes priority over any phase-completion transition in the same cycle.

Optional Feature:
- Macro UTURN_TIMEOUT_EN.
- Defined:
  - A timer counts from leaving IDLE. It reaching TIMEOUT_CYCLES in BACKUP..BRAKE -> FAULT.
  - FAULT: motors off, fault 1, uturn_finished 0. en low -> IDLE and fault clears.
- Undefined: no timer and no FAULT state; fault is tied 0.

Decomposition:
- Shared package uturn_pkg:
  - state enum (IDLE, BACKUP, LEAVE, SEEK, BRAKE, DONE, FAULT);
  - CENTRE_BIT = 2;
  - DIR_FWD = 1, DIR_REV = 0.
- Sub-module pwm_gen: parameter PERIOD; inputs clk, rst_n, restart, duty; output pwm. Instantiated once; both wheels share its output.

Test Plan:
- Reset low 3 cycles with en high, then release -> all outputs 0 during reset; BACKUP entered on the first edge after release.
- Small params (PWM_PERIOD=10, BACK_DUTY=4, SPIN_DUTY=6, BACK_CYCLES=50, DEBOUNCE=4, BRAKE_CYCLES=20). en=1, centre drops at cycle 70, returns at 150 -> cycle-by-cycle checks:
  - pwm 4/10 reverse until cycle 51;
  - spin at 6/10;
  - SEEK entered about 4 cycles after the drop;
  - BRAKE about 4 cycles after the return;
  - uturn_finished high 20 cycles later.
- Centre glitch: 3-cycle low pulse in LEAVE with DEBOUNCE=4 -> stays in LEAVE; a 4-cycle low pulse -> SEEK.
- en dropped mid-SEEK -> IDLE next edge, pwm 0 afterwards, uturn_finished never asserted.
- Hold en high in DONE for 100 cycles -> uturn_finished stays 1 and no new turn starts. en low -> finished 0. en high -> new BACKUP.
- With UTURN_TIMEOUT_EN, TIMEOUT_CYCLES=300, centre never returns -> FAULT at cycle 300, fault 1, motors off, cleared by en low. Without the macro -> spin continues indefinitely, fault stays 0.

Source files
------------

// File: rtl/uturn_pkg.sv
// Shared types and constants for the U-turn controller.
package uturn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BACKUP,
        LEAVE,
        SEEK,
        BRAKE,
        DONE,
        FAULT
    } state_t;

    localparam int unsigned CENTRE_BIT = 2;
    localparam logic        DIR_FWD    = 1'b1;
    localparam logic        DIR_REV    = 1'b0;

    function automatic logic is_moving(input state_t s);
        return s inside {BACKUP, LEAVE, SEEK, BRAKE};
    endfunction

endpackage

// File: rtl/uturn_ctrl_pwm_gen.sv
// Free-running PWM with a registered output; restart re-aligns the period to the
// first cycle of a new phase.
module pwm_gen #(
    parameter int unsigned PERIOD = 1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   restart,
    input  logic [$clog2(PERIOD):0] duty,
    output logic                   pwm
);
    localparam int unsigned CW = $clog2(PERIOD) + 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            pwm <= 1'b0;
        end else begin
            pwm <= (cnt < duty);
            if (restart || cnt == CW'(PERIOD - 1))
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uturn_ctrl.sv
// U-turn sequencer: back-off, spin off the line, spin to reacquire, brake, done.
// Define UTURN_TIMEOUT_EN to add the enable-to-done timeout and FAULT state.
module uturn_ctrl
    import uturn_pkg::*;
#(
    parameter int unsigned PWM_PERIOD     = 1000,
    parameter int unsigned SPIN_DUTY      = 600,
    parameter int unsigned BACK_DUTY      = 400,
    parameter int unsigned BACK_CYCLES    = 5000000,
    parameter int unsigned DEBOUNCE       = 16,
    parameter int unsigned BRAKE_CYCLES   = 1000000,
    parameter int unsigned TIMEOUT_CYCLES = 200000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [4:0] sensors,
    output logic       uturn_finished,
    output logic       busy,
    output logic       motor_l_dir,
    output logic       motor_r_dir,
    output logic       motor_l_pwm,
    output logic       motor_r_pwm,
    output logic       fault
);
    localparam int unsigned PW = $clog2(PWM_PERIOD) + 1;
    localparam int unsigned BW = $clog2(BACK_CYCLES) + 1;
    localparam int unsigned RW = $clog2(BRAKE_CYCLES) + 1;
    localparam int unsigned DW = $clog2(DEBOUNCE) + 1;

    state_t        state, next_state;
    logic [4:0]    sens_meta, sens_sync;
    logic          centre;
    logic          sensors_unused;
    logic [BW-1:0] back_cnt;
    logic [RW-1:0] brake_cnt;
    logic [DW-1:0] deb_cnt;
    logic [PW-1:0] duty;
    logic          restart;
    logic          pwm;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sens_meta <= '0;
            sens_sync <= '0;
        end else begin
            sens_meta <= sensors;
            sens_sync <= sens_meta;
        end
    end

    assign centre         = sens_sync[CENTRE_BIT];
    assign sensors_unused = ^sens_sync;

`ifdef UTURN_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] timer;

    always_ff @(posedge clk) begin
        if (!rst_n || state == IDLE)
            timer <= '0;
        else if (timer != '1)
            timer <= timer + TW'(1);
    end
`else
    logic timeout_unused;
    assign timeout_unused = |TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Abort (en low) is applied last so it overrides timeout and phase completion.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (en) next_state = BACKUP;
            BACKUP:  if (back_cnt == BW'(BACK_CYCLES - 1)) next_state = LEAVE;
            LEAVE:   if (!centre && deb_cnt == DW'(DEBOUNCE - 1)) next_state = SEEK;
            SEEK:    if (centre && deb_cnt == DW'(DEBOUNCE - 1)) next_state = BRAKE;
            BRAKE:   if (brake_cnt == RW'(BRAKE_CYCLES - 1)) next_state = DONE;
            DONE:    next_state = DONE;
            FAULT:   next_state = FAULT;
            default: next_state = IDLE;
        endcase
`ifdef UTURN_TIMEOUT_EN
        if (is_moving(state) && timer == TW'(TIMEOUT_CYCLES - 1))
            next_state = FAULT;
`endif
        if (!en && state != IDLE)
            next_state = IDLE;
    end

    always_comb begin
        duty = '0;
        case (state)
            BACKUP:      duty = PW'(BACK_DUTY);
            LEAVE, SEEK: duty = PW'(SPIN_DUTY);
            default:     duty = '0;
        endcase
    end

    assign restart = (next_state != state);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            back_cnt  <= '0;
            brake_cnt <= '0;
            deb_cnt   <= '0;
        end else begin
            if (state != BACKUP)
                back_cnt <= '0;
            else if (back_cnt != '1)
                back_cnt <= back_cnt + BW'(1);

            if (state != BRAKE)
                brake_cnt <= '0;
            else if (brake_cnt != '1)
                brake_cnt <= brake_cnt + RW'(1);

            if (restart)
                deb_cnt <= '0;
            else if ((state == LEAVE && !centre) || (state == SEEK && centre)) begin
                if (deb_cnt != '1)
                    deb_cnt <= deb_cnt + DW'(1);
            end else
                deb_cnt <= '0;
        end
    end

    // Motor-side outputs follow the current phase one cycle later, in step with
    // the registered PWM; completion and fault flags track the phase being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy           <= 1'b0;
            motor_l_dir    <= 1'b0;
            motor_r_dir    <= 1'b0;
            uturn_finished <= 1'b0;
        end else begin
            busy           <= is_moving(state);
            motor_l_dir    <= (state == LEAVE || state == SEEK) ? DIR_FWD : DIR_REV;
            motor_r_dir    <= DIR_REV;
            uturn_finished <= (next_state == DONE);
        end
    end

`ifdef UTURN_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            fault <= 1'b0;
        else
            fault <= (next_state == FAULT);
    end
`else
    assign fault = 1'b0;
`endif

    pwm_gen #(
        .PERIOD (PWM_PERIOD)
    ) u_pwm (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .duty    (duty),
        .pwm     (pwm)
    );

    assign motor_l_pwm = pwm;
    assign motor_r_pwm = pwm;

endmodule

// File: tb/tb_uturn_ctrl.sv
// Directed bench for uturn_ctrl with shortened phase parameters; expectations
// switch on UTURN_TIMEOUT_EN for the final stuck-in-SEEK scenario.
module tb_uturn_ctrl;

    localparam int P = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [4:0] sensors;
    logic       uturn_finished, busy, motor_l_dir, motor_r_dir;
    logic       motor_l_pwm, motor_r_pwm, fault;

    int checks = 0;
    int errors = 0;

    // Expected values of the one-cycle-lagged motor outputs, from the previous cycle.
    logic m_pwm  = 1'b0;
    logic m_ldir = 1'b0;
    logic m_rdir = 1'b0;
    logic m_busy = 1'b0;
    logic m_dchk = 1'b0;

    uturn_ctrl #(
        .PWM_PERIOD     (10),
        .SPIN_DUTY      (6),
        .BACK_DUTY      (4),
        .BACK_CYCLES    (50),
        .DEBOUNCE       (4),
        .BRAKE_CYCLES   (20),
        .TIMEOUT_CYCLES (300)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .sensors        (sensors),
        .uturn_finished (uturn_finished),
        .busy           (busy),
        .motor_l_dir    (motor_l_dir),
        .motor_r_dir    (motor_r_dir),
        .motor_l_pwm    (motor_l_pwm),
        .motor_r_pwm    (motor_r_pwm),
        .fault          (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // n cycles spent in one phase; start = PWM count in the first of them.
    task automatic run(input string tag, input int n, input int start, input int duty,
                       input logic ldir, input logic rdir, input logic moving,
                       input logic fin, input logic flt);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, ".pwm_l"}, motor_l_pwm, m_pwm);
            chk({tag, ".pwm_r"}, motor_r_pwm, m_pwm);
            if (m_dchk) begin
                chk({tag, ".dir_l"}, motor_l_dir, m_ldir);
                chk({tag, ".dir_r"}, motor_r_dir, m_rdir);
            end
            chk({tag, ".busy"}, busy, m_busy);
            chk({tag, ".finished"}, uturn_finished, fin);
            chk({tag, ".fault"}, fault, flt);
            m_pwm  = (duty != 0) && (((start + i) % P) < duty);
            m_ldir = ldir;
            m_rdir = rdir;
            m_busy = moving;
            m_dchk = (duty != 0);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        sensors = 5'b00100;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst.pwm_l", motor_l_pwm, 1'b0);
            chk("rst.pwm_r", motor_r_pwm, 1'b0);
            chk("rst.dir_l", motor_l_dir, 1'b0);
            chk("rst.dir_r", motor_r_dir, 1'b0);
            chk("rst.busy", busy, 1'b0);
            chk("rst.finished", uturn_finished, 1'b0);
            chk("rst.fault", fault, 1'b0);
        end
        rst_n = 1'b1;

        // Full turn: drop at cycle 70, return at 150.
        run("backup1", 50, 0, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run("leave1a", 20, 0, 6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        sensors = 5'b00000;
        run("leave1b", 5, 20, 6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run("seek1a", 75, 0, 6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        sensors = 5'b00100;
        run("seek1b", 5, 75, 6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run("brake1", 20, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run("done1", 100, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        en = 1'b0;
        run("idle1", 3, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'b1;

        // Second turn: glitch rejection, then abort mid-SEEK.
        run("backup2", 50, 0, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run("leave2a", 10, 0, 6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        sensors = 5'b00000;
        run("leave2b", 3, 10, 6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        sensors = 5'b00100;
        run("leave2c", 10, 13, 6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        sensors = 5'b00000;
        run("leave2d", 4, 23, 6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        sensors = 5'b00100;
        run("leave2e", 1, 27, 6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run("seek2", 2, 0, 6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        en = 1'b0;
        run("abort2", 20, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Third turn: line never comes back.
        sensors = 5'b00000;
        run("idle3", 3, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        run("backup3", 50, 0, 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run("leave3", 4, 0, 6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef UTURN_TIMEOUT_EN
        run("seek3", 246, 0, 6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run("fault3", 10, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`else
        run("seek3", 256, 0, 6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
        en = 1'b0;
        run("idle4", 3, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
